cordic_req_arbiter: RTL and testbench



---
 rtl/cordic_arb_pkg.sv | 21 ++
 rtl/cordic_tag_fifo.sv | 69 ++++++
 rtl/cordic_req_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_cordic_req_arbiter.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cordic_arb_pkg.sv
// rtl/cordic_arb_pkg.sv - shared types and helpers for the CORDIC request arbiter
package cordic_arb_pkg;

  // Default requester count and the tag width that goes with it
  localparam int NUM_REQ_DFLT = 4;
  localparam int ID_W         = $clog2(NUM_REQ_DFLT);

  typedef logic [ID_W-1:0] tag_t;

  // Operating mode handed to the CORDIC core
  typedef enum logic {
    MODE_ROT = 1'b0,
    MODE_VEC = 1'b1
  } mode_e;

  // Tag width for an arbitrary requester count (never narrower than one bit)
  function automatic int id_width(input int num_req);
    return (num_req > 1) ? $clog2(num_req) : 1;
  endfunction

endpackage

// File: rtl/cordic_tag_fifo.sv
// rtl/cordic_tag_fifo.sv - in-flight requester tag FIFO with full/empty flags and occupancy
module cordic_tag_fifo #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   nreset,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       push_data_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       pop_data_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  // DEPTH is a power of two, so the pointers wrap for free
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full_o     = (count_q == DEPTH_C);
  assign empty_o    = (count_q == '0);
  assign count_o    = count_q;
  assign pop_data_o = mem_q[rd_ptr_q];

  // A push into a full FIFO is fine when the head leaves in the same cycle
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  // Pointer and occupancy next-state
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Control state, cleared by reset so all tags are flushed
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Tag storage; contents are only meaningful behind the count
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/cordic_req_arbiter.sv
// rtl/cordic_req_arbiter.sv - shares one CORDIC core between NUM_REQ requesters; CORDIC_ARB_PRIO0_EN gives requester 0 fixed priority
module cordic_req_arbiter
  import cordic_arb_pkg::*;
#(
  parameter int NUM_REQ         = 4,
  parameter int CORDIC_WIDTH    = 22,
  parameter int DATA_WIDTH      = 16,
  parameter int MAX_OUTSTANDING = 16
) (
  input  logic                            clk,
  input  logic                            nreset,
  input  logic [NUM_REQ-1:0]              req_vld,
  output logic [NUM_REQ-1:0]              req_rdy,
  input  logic [NUM_REQ*CORDIC_WIDTH-1:0] req_x,
  input  logic [NUM_REQ*CORDIC_WIDTH-1:0] req_y,
  input  logic [NUM_REQ-1:0]              req_mode,
  output logic                            core_en,
  output logic [CORDIC_WIDTH-1:0]         core_x,
  output logic [CORDIC_WIDTH-1:0]         core_y,
  output logic                            core_mode,
  input  logic                            core_vld,
  input  logic [DATA_WIDTH-1:0]           core_x_res,
  input  logic [DATA_WIDTH-1:0]           core_y_res,
  output logic [NUM_REQ-1:0]              rsp_vld,
  output logic [DATA_WIDTH-1:0]           rsp_x,
  output logic [DATA_WIDTH-1:0]           rsp_y,
  output logic                            busy,
  output logic                            err
);

  localparam int TAG_W = id_width(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_OUTSTANDING) + 1;
  localparam logic [TAG_W:0] NUM_REQ_W = (TAG_W + 1)'(NUM_REQ);

  // Arbitration
  logic [TAG_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [TAG_W:0]   scan_idx;
  logic [TAG_W-1:0] rr_idx, grant_idx;
  logic             rr_any, grant_any, can_issue, accept;

  // Issue and response registers
  logic                    core_en_q, core_en_d;
  logic [CORDIC_WIDTH-1:0] core_x_q, core_x_d;
  logic [CORDIC_WIDTH-1:0] core_y_q, core_y_d;
  mode_e                   core_mode_q, core_mode_d;
  logic [NUM_REQ-1:0]      rsp_vld_q, rsp_vld_d;
  logic [DATA_WIDTH-1:0]   rsp_x_q, rsp_x_d;
  logic [DATA_WIDTH-1:0]   rsp_y_q, rsp_y_d;
  logic                    err_q, err_d;

  // Tag FIFO
  logic             fifo_pop, fifo_full, fifo_empty;
  logic [TAG_W-1:0] pop_tag;
  logic [CNT_W-1:0] fifo_count;

  // Round-robin scan: the pending requester closest at or after rr_ptr_q wins
  always_comb begin
    rr_any   = 1'b0;
    rr_idx   = '0;
    scan_idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      scan_idx = {1'b0, rr_ptr_q} + k[TAG_W:0];
      if (scan_idx >= NUM_REQ_W) scan_idx = scan_idx - NUM_REQ_W;
      if (req_vld[scan_idx[TAG_W-1:0]]) begin
        rr_any = 1'b1;
        rr_idx = scan_idx[TAG_W-1:0];
      end
    end
  end

  // Final grant, with requester 0 overriding the rotation when prioritised
  always_comb begin
    grant_any = rr_any;
    grant_idx = rr_idx;
`ifdef CORDIC_ARB_PRIO0_EN
    if (req_vld[0]) begin
      grant_any = 1'b1;
      grant_idx = '0;
    end
`endif
  end

  // No credit left means no grant; the grant is also held low while in reset
  assign can_issue = nreset & ~fifo_full;
  assign accept    = can_issue & grant_any;

  // One-hot ready towards the winning requester
  always_comb begin
    req_rdy = '0;
    if (accept) req_rdy[grant_idx] = 1'b1;
  end

  // Pointer moves past the winner; a prioritised requester 0 leaves it alone
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (accept) begin
      if ({1'b0, grant_idx} == NUM_REQ_W - 1'b1) rr_ptr_d = '0;
      else                                       rr_ptr_d = grant_idx + 1'b1;
`ifdef CORDIC_ARB_PRIO0_EN
      if (grant_idx == '0) rr_ptr_d = rr_ptr_q;
`endif
    end
  end

  // A result with nothing in flight is dropped and flagged instead of popped
  assign fifo_pop = core_vld & ~fifo_empty;

  // Next-state for the issue, response and error registers
  always_comb begin
    core_en_d   = accept;
    core_x_d    = core_x_q;
    core_y_d    = core_y_q;
    core_mode_d = core_mode_q;
    if (accept) begin
      core_x_d    = req_x[grant_idx*CORDIC_WIDTH +: CORDIC_WIDTH];
      core_y_d    = req_y[grant_idx*CORDIC_WIDTH +: CORDIC_WIDTH];
      core_mode_d = mode_e'(req_mode[grant_idx]);
    end
    rsp_vld_d = '0;
    rsp_x_d   = rsp_x_q;
    rsp_y_d   = rsp_y_q;
    if (fifo_pop) begin
      rsp_vld_d[pop_tag] = 1'b1;
      rsp_x_d            = core_x_res;
      rsp_y_d            = core_y_res;
    end
    err_d = err_q | (core_vld & fifo_empty);
  end

  // Registered state; reset flushes everything including the pointer
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      rr_ptr_q    <= '0;
      core_en_q   <= 1'b0;
      core_x_q    <= '0;
      core_y_q    <= '0;
      core_mode_q <= MODE_ROT;
      rsp_vld_q   <= '0;
      rsp_x_q     <= '0;
      rsp_y_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      core_en_q   <= core_en_d;
      core_x_q    <= core_x_d;
      core_y_q    <= core_y_d;
      core_mode_q <= core_mode_d;
      rsp_vld_q   <= rsp_vld_d;
      rsp_x_q     <= rsp_x_d;
      rsp_y_q     <= rsp_y_d;
      err_q       <= err_d;
    end
  end

  cordic_tag_fifo #(
    .WIDTH (TAG_W),
    .DEPTH (MAX_OUTSTANDING)
  ) u_tag_fifo (
    .clk         (clk),
    .nreset      (nreset),
    .push_i      (accept),
    .push_data_i (grant_idx),
    .pop_i       (fifo_pop),
    .pop_data_o  (pop_tag),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count)
  );

  assign core_en   = core_en_q;
  assign core_x    = core_x_q;
  assign core_y    = core_y_q;
  assign core_mode = core_mode_q;
  assign rsp_vld   = rsp_vld_q;
  assign rsp_x     = rsp_x_q;
  assign rsp_y     = rsp_y_q;
  assign err       = err_q;
  assign busy      = (fifo_count != '0) | core_en_q;

endmodule

// File: tb/tb_cordic_req_arbiter.sv
// tb/tb_cordic_req_arbiter.sv - randomized self-checking bench for cordic_req_arbiter
module tb_cordic_req_arbiter;

  localparam int N    = 4;
  localparam int CW   = 22;
  localparam int DW   = 16;
  localparam int MAXO = 16;
  localparam int LAT  = 18;
`ifdef CORDIC_ARB_PRIO0_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            nreset;
  logic [N-1:0]    req_vld, req_rdy, req_mode, rsp_vld;
  logic [N*CW-1:0] req_x, req_y;
  logic            core_en, core_mode, core_vld, busy, err;
  logic [CW-1:0]   core_x, core_y;
  logic [DW-1:0]   core_x_res, core_y_res, rsp_x, rsp_y;

  always #5 clk = ~clk;

  cordic_req_arbiter #(
    .NUM_REQ(N), .CORDIC_WIDTH(CW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk(clk), .nreset(nreset),
    .req_vld(req_vld), .req_rdy(req_rdy), .req_x(req_x), .req_y(req_y), .req_mode(req_mode),
    .core_en(core_en), .core_x(core_x), .core_y(core_y), .core_mode(core_mode),
    .core_vld(core_vld), .core_x_res(core_x_res), .core_y_res(core_y_res),
    .rsp_vld(rsp_vld), .rsp_x(rsp_x), .rsp_y(rsp_y), .busy(busy), .err(err)
  );

  typedef struct { int due; logic [DW-1:0] x; logic [DW-1:0] y; } res_t;

  int   n_checks = 0;
  int   n_errors = 0;
  res_t core_q[$];
  int   exp_tags[$];
  int   grant_log[$];
  int   m_ptr, cyc, obs_cnt;
  bit   m_err, core_hold, spurious, fixed_res;
  logic [N-1:0]  last_rsp_vld;
  logic [DW-1:0] last_rsp_x;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int model_grant(input logic [N-1:0] v);
    if (!nreset) return -1;
    if (exp_tags.size() >= MAXO) return -1;
    if (PRIO && v[0]) return 0;
    for (int k = 0; k < N; k++)
      if (v[(m_ptr + k) % N]) return (m_ptr + k) % N;
    return -1;
  endfunction

  task automatic randomize_operands();
    for (int i = 0; i < N; i++) begin
      req_x[i*CW +: CW] = CW'($urandom);
      req_y[i*CW +: CW] = CW'($urandom);
    end
    req_mode = N'($urandom);
  endtask

  task automatic cycle();
    int g, t;
    logic [N-1:0]  er;
    logic [CW-1:0] ex, ey;
    logic          em;
    logic [DW-1:0] rx, ry;
    bit acc, pop_ok;
    res_t r;
    core_vld = 1'b0;
    if (spurious) core_vld = 1'b1;
    else if (!core_hold && core_q.size() > 0 && core_q[0].due <= cyc) begin
      core_vld   = 1'b1;
      core_x_res = core_q[0].x;
      core_y_res = core_q[0].y;
    end
    #1;
    g  = model_grant(req_vld);
    er = '0;
    if (g >= 0) er[g] = 1'b1;
    check("req_rdy", req_rdy, er);
    for (int i = 0; i < N; i++)
      if (req_rdy[i]) begin grant_log.push_back(i); obs_cnt++; end
    acc = (g >= 0);
    ex = '0; ey = '0; em = 1'b0;
    if (acc) begin
      ex = req_x[g*CW +: CW];
      ey = req_y[g*CW +: CW];
      em = req_mode[g];
    end
    rx = core_x_res;
    ry = core_y_res;
    @(posedge clk);
    cyc++;
    pop_ok = 1'b0;
    t      = 0;
    if (core_vld) begin
      if (exp_tags.size() == 0) m_err = 1'b1;
      else begin t = exp_tags.pop_front(); pop_ok = 1'b1; end
      if (!spurious && core_q.size() > 0) r = core_q.pop_front();
    end
    if (acc) begin
      exp_tags.push_back(g);
      if (!(PRIO && g == 0)) m_ptr = (g + 1) % N;
      r.due = cyc + LAT;
      r.x   = fixed_res ? 16'h1234 : DW'($urandom);
      r.y   = fixed_res ? 16'h5678 : DW'($urandom);
      core_q.push_back(r);
    end
    #1;
    check("core_en", core_en, acc);
    if (acc) begin
      check("core_x", core_x, ex);
      check("core_y", core_y, ey);
      check("core_mode", core_mode, em);
    end
    er = '0;
    if (pop_ok) er[t] = 1'b1;
    check("rsp_vld", rsp_vld, er);
    if (pop_ok) begin
      check("rsp_x", rsp_x, rx);
      check("rsp_y", rsp_y, ry);
    end
    check("err", err, m_err);
    check("busy", busy, (exp_tags.size() != 0) || acc);
    if (rsp_vld != '0) begin last_rsp_vld = rsp_vld; last_rsp_x = rsp_x; end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_rdy"}, req_rdy, '0);
    check({tag, "_core_en"}, core_en, 0);
    check({tag, "_core_x"}, core_x, 0);
    check({tag, "_core_y"}, core_y, 0);
    check({tag, "_core_mode"}, core_mode, 0);
    check({tag, "_rsp_vld"}, rsp_vld, 0);
    check({tag, "_rsp_x"}, rsp_x, 0);
    check({tag, "_rsp_y"}, rsp_y, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_err"}, err, 0);
  endtask

  task automatic do_reset();
    nreset = 1'b0;
    #1;
    check_reset_outputs("rst");
    exp_tags.delete();
    core_q.delete();
    m_ptr = 0;
    m_err = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("rst_hold");
    @(negedge clk);
    nreset = 1'b1;
    #1;
    check("post_rst_busy", busy, 0);
  endtask

  task automatic drain(input int n);
    req_vld   = '0;
    core_hold = 1'b0;
    repeat (n) cycle();
  endtask

  initial begin
    nreset = 1'b1;
    req_vld = '1; req_x = '0; req_y = '0; req_mode = '0;
    core_vld = 1'b0; core_x_res = '0; core_y_res = '0;
    core_hold = 1'b0; spurious = 1'b0; fixed_res = 1'b0;
    cyc = 0; m_ptr = 0; m_err = 1'b0; obs_cnt = 0;
    last_rsp_vld = '0; last_rsp_x = '0;
    #2;
    do_reset();

    // All four requesting: rotation from requester 0
    grant_log.delete();
    req_vld = 4'b1111;
    repeat (8) begin randomize_operands(); cycle(); end
    for (int i = 0; i < 8; i++) begin
      if (grant_log.size() > i) check("rr_order", grant_log[i], PRIO ? 0 : i % N);
      else check("rr_order_missing", 0, 1);
    end
    if (PRIO) begin
      grant_log.delete();
      req_vld = 4'b1110;
      repeat (6) begin randomize_operands(); cycle(); end
      for (int i = 0; i < 6; i++) begin
        if (grant_log.size() > i) check("prio_rot", grant_log[i], (i % 3) + 1);
        else check("prio_rot_missing", 0, 1);
      end
    end
    drain(LAT + 12);

    // Single request with fixed operands and a fixed core result
    req_x = '0; req_y = '0; req_mode = '0;
    req_x[0 +: CW] = 22'h00100;
    req_y[0 +: CW] = 22'h00200;
    fixed_res = 1'b1;
    req_vld = 4'b0001;
    cycle();
    drain(LAT + 4);
    check("single_rsp_vld", last_rsp_vld, 4'b0001);
    check("single_rsp_x", last_rsp_x, 16'h1234);
    fixed_res = 1'b0;

    // Core stalled, requester 2 streaming until credit runs out
    obs_cnt   = 0;
    core_hold = 1'b1;
    req_vld   = 4'b0100;
    repeat (20) begin randomize_operands(); cycle(); end
    check("stall_accepts", obs_cnt, MAXO);
    core_hold = 1'b0; cycle();
    core_hold = 1'b1; cycle(); cycle();
    core_hold = 1'b0; cycle(); cycle();
    core_hold = 1'b1; repeat (3) cycle();
    check("refill_accepts", obs_cnt, MAXO + 3);
    drain(MAXO + LAT + 6);

    // Result strobe with nothing in flight
    spurious = 1'b1; cycle();
    spurious = 1'b0; repeat (3) cycle();
    check("err_sticky", err, 1);

    // Random traffic with occasional core hold-off
    repeat (400) begin
      req_vld   = N'($urandom);
      randomize_operands();
      core_hold = ($urandom_range(0, 3) == 0);
      cycle();
    end
    drain(MAXO + LAT + 6);

    // Reset with requests in flight
    core_hold = 1'b1;
    req_vld   = 4'b1111;
    repeat (5) cycle();
    do_reset();
    core_hold = 1'b0;
    grant_log.delete();
    cycle();
    if (grant_log.size() > 0) check("post_rst_grant", grant_log[0], 0);
    else check("post_rst_grant_missing", 0, 1);
    drain(LAT + 6);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
